// File: rtl/lock_code_sender.sv
// Transmit side of the serial code-lock link: shifts a latched code MSB-first onto B,
// samples the lock's verdict and tracks consecutive failures up to a lockout.
module lock_code_sender #(
    parameter int CODE_W    = 4,
    parameter int MAX_TRIES = 3,
    parameter int TRY_W     = 2
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              start,
    input  logic [CODE_W-1:0] code,
    input  logic              Correct,
    input  logic              Incorrect,
    output logic              B,
    output logic              busy,
    output logic              granted,
    output logic              denied,
    output logic              proto_err,
    output logic [TRY_W-1:0]  tries_left,
    output logic              locked_out
);

    localparam int PH_W = $clog2(CODE_W + 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CODE_W);
    localparam logic [PH_W-1:0]  PH_SLAST = PH_W'(CODE_W - 1);
    localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        SEND,
        VERDICT,
        LOCKED
    } state_t;

    state_t            state;
    logic [PH_W-1:0]   phase;
    logic [CODE_W-1:0] sreg;

    // phase tracks the lock's frame position, so it never stops regardless of state
    always_ff @(posedge clock) begin
        if (Reset) begin
            state      <= IDLE;
            phase      <= '0;
            sreg       <= '0;
            B          <= 1'b0;
            busy       <= 1'b0;
            granted    <= 1'b0;
            denied     <= 1'b0;
            proto_err  <= 1'b0;
            tries_left <= TRY_MAX;
            locked_out <= 1'b0;
        end else begin
            granted   <= 1'b0;
            denied    <= 1'b0;
            proto_err <= 1'b0;
            phase     <= (phase == PH_LAST) ? '0 : phase + 1'b1;

            case (state)
                IDLE: begin
                    B <= 1'b0;
                    if (start && !locked_out) begin
                        busy <= 1'b1;
                        // accepted in the verdict slot: the very next cycle opens a frame
                        if (phase == PH_LAST) begin
                            state <= SEND;
                            B     <= code[CODE_W-1];
                            sreg  <= code << 1;
                        end else begin
                            state <= ALIGN;
                            sreg  <= code;
                        end
                    end
                end

                ALIGN: begin
                    B <= 1'b0;
                    if (phase == PH_LAST) begin
                        state <= SEND;
                        B     <= sreg[CODE_W-1];
                        sreg  <= sreg << 1;
                    end
                end

                SEND: begin
                    if (phase == PH_SLAST) begin
                        state <= VERDICT;
                        B     <= 1'b0;
                    end else begin
                        B    <= sreg[CODE_W-1];
                        sreg <= sreg << 1;
                    end
                end

                VERDICT: begin
                    B    <= 1'b0;
                    busy <= 1'b0;
                    if (Correct && !Incorrect) begin
                        granted    <= 1'b1;
                        tries_left <= TRY_MAX;
                        state      <= IDLE;
                    end else begin
                        denied    <= 1'b1;
                        proto_err <= (Correct == Incorrect);
                        if (tries_left <= TRY_W'(1)) begin
                            tries_left <= '0;
                            locked_out <= 1'b1;
                            state      <= LOCKED;
                        end else begin
                            tries_left <= tries_left - 1'b1;
                            state      <= IDLE;
                        end
                    end
                end

                LOCKED: begin
                    B          <= 1'b0;
                    busy       <= 1'b0;
                    locked_out <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                    B     <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_code_sender.sv
// Bench for lock_code_sender: a timeline model (accept time, first-bit time, verdict time)
// is checked against the DUT every cycle, under directed scenarios and random traffic.
module tb_lock_code_sender;

    localparam int CODE_W    = 4;
    localparam int MAX_TRIES = 3;
    localparam int TRY_W     = 2;

    logic              clock = 1'b0;
    logic              Reset = 1'b1;
    logic              start = 1'b0;
    logic [CODE_W-1:0] code  = '0;
    logic              Correct = 1'b0;
    logic              Incorrect = 1'b0;
    logic              B, busy, granted, denied, proto_err, locked_out;
    logic [TRY_W-1:0]  tries_left;

    lock_code_sender #(.CODE_W(CODE_W), .MAX_TRIES(MAX_TRIES), .TRY_W(TRY_W)) dut (
        .clock(clock), .Reset(Reset), .start(start), .code(code),
        .Correct(Correct), .Incorrect(Incorrect), .B(B), .busy(busy),
        .granted(granted), .denied(denied), .proto_err(proto_err),
        .tries_left(tries_left), .locked_out(locked_out)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // model: frame position plus absolute times of the attempt in flight
    bit                m_valid = 0;
    int                m_ph = 0;
    int                m_tries = MAX_TRIES;
    bit                m_locked = 0;
    bit                m_inflight = 0;
    logic [CODE_W-1:0] m_code = '0;
    longint            t = 0, t_acc = 0, t_first = 0, t_res = -1;
    bit                r_g = 0, r_d = 0, r_pe = 0;

    logic [7:0] b_hist = '0;
    int g_cnt = 0, d_cnt = 0, p_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, t);
        end
    endtask

    // one clock cycle: check this cycle's outputs, drive this cycle's inputs, advance the model
    task automatic step(input bit s, input logic [CODE_W-1:0] c, input bit cor, input bit inc,
                        input bit rst);
        logic eB, eBusy, eg, ed, ep;
        bit   was_in, was_lk;
        int   ph0;
        @(negedge clock);
        if (m_valid) begin
            eBusy = m_inflight && (t > t_acc);
            eB    = 1'b0;
            if (m_inflight && t >= t_first && t < t_first + CODE_W)
                eB = m_code[CODE_W-1-int'(t - t_first)];
            eg = (t == t_res) && r_g;
            ed = (t == t_res) && r_d;
            ep = (t == t_res) && r_pe;
            chk("B", B, eB);
            chk("busy", busy, eBusy);
            chk("granted", granted, eg);
            chk("denied", denied, ed);
            chk("proto_err", proto_err, ep);
            chk("tries_left", tries_left, m_tries);
            chk("locked_out", locked_out, m_locked);
        end
        b_hist = {b_hist[6:0], B};
        if (granted === 1'b1) g_cnt++;
        if (denied === 1'b1) d_cnt++;
        if (proto_err === 1'b1) p_cnt++;

        start = s; code = c; Correct = cor; Incorrect = inc; Reset = rst;

        if (rst) begin
            m_valid = 1; m_ph = 0; m_tries = MAX_TRIES; m_locked = 0;
            m_inflight = 0; t_res = -1;
        end else if (m_valid) begin
            was_in = m_inflight; was_lk = m_locked; ph0 = m_ph;
            if (m_inflight && t == t_first + CODE_W) begin
                r_g  = cor && !inc;
                r_d  = !r_g;
                r_pe = (cor == inc);
                if (r_g) m_tries = MAX_TRIES;
                else if (m_tries > 0) m_tries--;
                m_locked   = (m_tries == 0);
                m_inflight = 0;
                t_res      = t + 1;
            end
            if (!was_in && !was_lk && s) begin
                m_inflight = 1;
                m_code     = c;
                t_acc      = t;
                t_first    = t + (CODE_W + 1 - ph0);
            end
            m_ph = (m_ph + 1) % (CODE_W + 1);
        end
        t++;
    endtask

    task automatic finish_attempt(input bit s, input bit cor, input bit inc);
        int n = 0;
        while (m_inflight && n < 40) begin
            step(s, CODE_W'($urandom), cor, inc, 0);
            n++;
        end
        if (n >= 40) chk("attempt_timeout", 1, 0);
        step(0, '0, 0, 1, 0);
    endtask

    task automatic attempt(input logic [CODE_W-1:0] c, input bit cor, input bit inc);
        step(1, c, 0, 0, 0);
        finish_attempt(0, cor, inc);
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        while (m_ph != p && n < 10) begin
            step(0, '0, 0, 1, 0);
            n++;
        end
    endtask

    initial begin
        int n;
        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 1);
        chk("rst_tries", tries_left, 3);
        chk("rst_locked", locked_out, 0);
        chk("rst_busy", busy, 0);

        // code 1010 accepted at phase 0; bits land in the following frame
        step(1, 4'b1010, 0, 0, 0);
        repeat (4) step(0, 4'b0000, 0, 0, 0);
        b_hist = '0; g_cnt = 0;
        repeat (4) step(0, 4'b0101, 0, 1, 0);
        chk("bits_1010", b_hist[3:0], 4'b1010);
        step(0, '0, 1, 0, 0);
        step(0, '0, 0, 1, 0);
        chk("grant_once", g_cnt, 1);
        chk("grant_tries", tries_left, 3);
        chk("grant_busy", busy, 0);

        d_cnt = 0;
        attempt(4'b0110, 0, 1);
        chk("deny_tries", tries_left, 2);
        chk("deny_cnt", d_cnt, 1);
        attempt(4'b1100, 1, 0);
        chk("regrant_tries", tries_left, 3);

        attempt(4'b0001, 0, 1); chk("wrong1", tries_left, 2);
        attempt(4'b0010, 0, 1); chk("wrong2", tries_left, 1);
        attempt(4'b0011, 0, 1); chk("wrong3", tries_left, 0);
        chk("lockout", locked_out, 1);
        attempt(4'b1111, 1, 0);
        chk("locked_busy", busy, 0);
        chk("locked_tries", tries_left, 0);

        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 1, 0);
        chk("unlock", locked_out, 0);
        chk("unlock_tries", tries_left, 3);

        // accept in the verdict slot: first bit next cycle
        wait_phase(CODE_W);
        step(1, 4'b1000, 0, 0, 0);
        step(0, 4'b0000, 0, 0, 0);
        chk("ph4_first_bit", B, 1);
        finish_attempt(1, 1, 0);

        // accept at phase 1, re-pulse start while busy
        wait_phase(1);
        step(1, 4'b1000, 0, 0, 0);
        repeat (3) step(1, 4'b0111, 0, 0, 0);
        chk("ph1_wait", B, 0);
        step(1, 4'b0111, 0, 0, 0);
        chk("ph1_first_bit", B, 1);
        finish_attempt(1, 1, 0);

        p_cnt = 0;
        attempt(4'b0101, 1, 1);
        chk("proto_both_tries", tries_left, 2);
        attempt(4'b0101, 0, 0);
        chk("proto_none_tries", tries_left, 1);
        chk("proto_cnt", p_cnt, 2);

        // reset during SEND phase 2
        step(0, '0, 0, 0, 1);
        step(1, 4'b1111, 0, 0, 0);
        n = 0;
        while (!(m_inflight && t == t_first + 2) && n < 20) begin
            step(0, 4'b1111, 0, 0, 0);
            n++;
        end
        g_cnt = 0; d_cnt = 0;
        step(0, '0, 0, 0, 1);
        step(0, '0, 1, 0, 0);
        chk("midrst_B", B, 0);
        chk("midrst_busy", busy, 0);
        repeat (CODE_W + 2) step(0, '0, 1, 0, 0);
        chk("midrst_nopulse", g_cnt + d_cnt, 0);

        repeat (20) step(0, '0, 0, 1, 0);
        chk("idle_incorrect", tries_left, 3);

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            step($urandom_range(0, 3) == 0, CODE_W'($urandom),
                 r < 5 || r == 9, r >= 5, $urandom_range(0, 149) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
